// File: rtl/data_out_uart_tx.sv
// Watches the CPU data_out byte, queues every change (or forced resend) in a
// small FIFO and serialises the queue as 8N1 UART frames on tx.
module data_out_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    data_in,
    input  logic                          force_send,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state;
    logic [7:0]         prev_byte;
    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [7:0]         shift_reg;
    logic [2:0]         bit_idx;
    logic [CNT_W-1:0]   baud;

    logic               push_c;
    logic               pop_c;
    logic               full_c;
    logic               accept_c;
    logic               baud_end_c;
    logic               idle_nxt_c;
    logic [LVL_W-1:0]   level_nxt_c;

    // Capture/FIFO handshake; a pop frees the slot for a same-cycle push when full.
    always_comb begin
        push_c      = (data_in != prev_byte) | force_send;
        full_c      = (fifo_level == LVL_W'(FIFO_DEPTH));
        pop_c       = (state == IDLE) && (fifo_level != '0);
        accept_c    = push_c && (!full_c || pop_c);
        baud_end_c  = (baud == CNT_W'(CLKS_PER_BIT - 1));
        idle_nxt_c  = ((state == IDLE) && !pop_c) || ((state == STOP) && baud_end_c);
        level_nxt_c = fifo_level;
        if (accept_c && !pop_c) begin
            level_nxt_c = fifo_level + LVL_W'(1);
        end else if (!accept_c && pop_c) begin
            level_nxt_c = fifo_level - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && accept_c) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // FIFO bookkeeping plus the frame FSM; tx is set one edge ahead of each bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tx         <= 1'b1;
            busy       <= 1'b0;
            fifo_level <= '0;
            overflow   <= 1'b0;
            prev_byte  <= 8'h00;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            shift_reg  <= 8'h00;
            bit_idx    <= 3'd0;
            baud       <= '0;
        end else begin
            prev_byte  <= data_in;
            fifo_level <= level_nxt_c;
            busy       <= !idle_nxt_c || (level_nxt_c != '0);
            if (accept_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (push_c && full_c && !pop_c) begin
                overflow <= 1'b1;
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            case (state)
                IDLE: begin
                    tx   <= 1'b1;
                    baud <= '0;
                    if (pop_c) begin
                        shift_reg <= mem[rd_ptr];
                        tx        <= 1'b0;
                        state     <= START;
                    end
                end
                START: begin
                    if (baud_end_c) begin
                        baud    <= '0;
                        bit_idx <= 3'd0;
                        tx      <= shift_reg[0];
                        state   <= DATA;
                    end else begin
                        baud <= baud + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (baud_end_c) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shift_reg[bit_idx + 3'd1];
                        end
                    end else begin
                        baud <= baud + CNT_W'(1);
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (baud_end_c) begin
                        baud  <= '0;
                        state <= IDLE;
                    end else begin
                        baud <= baud + CNT_W'(1);
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_out_uart_tx.sv
// Directed bench for data_out_uart_tx: cycle-exact tx/busy/level checks plus a
// UART receiver that decodes frames against a queue of expected bytes.
module tb_data_out_uart_tx;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       force_send = 1'b0;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_level;
    logic       overflow;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q [$];

    data_out_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .force_send (force_send),
        .tx         (tx),
        .busy       (busy),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        force_send = 1'b0;
        data_in    = 8'h00;
        step();
        step();
        rst = 1'b0;
    endtask

    // Called in the first start-bit cycle; checks all 40 cycles of the frame.
    task automatic check_frame(input logic [7:0] b, input string tag);
        logic e;
        for (int j = 0; j < 40; j++) begin
            if (j < 4)       e = 1'b0;
            else if (j < 36) e = b[(j - 4) / 4];
            else             e = 1'b1;
            chk({tag, "_tx"}, 32'(tx), 32'(e));
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            step();
        end
    endtask

    // Host-side receiver: samples mid-bit, abandons frames cut by reset.
    logic [7:0] rx_byte;
    logic       rx_abort;
    logic       rx_start;
    logic       rx_stop;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                rx_abort = 1'b0;
                rx_byte  = 8'h00;
                repeat (CPB / 2) begin @(negedge clk); rx_abort |= rst; end
                rx_start = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) begin @(negedge clk); rx_abort |= rst; end
                    rx_byte[i] = tx;
                end
                repeat (CPB) begin @(negedge clk); rx_abort |= rst; end
                rx_stop = tx;
                if (!rx_abort) begin
                    chk("rx_start", 32'(rx_start), 32'd0);
                    chk("rx_stop", 32'(rx_stop), 32'd1);
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $error("FAIL rx_unexpected: observed byte %0h expected none", rx_byte);
                    end else begin
                        chk("rx_byte", 32'(rx_byte), 32'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        do_reset();
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);

        // 1: single A5 frame, latency and end of busy
        repeat (10) step();
        data_in = 8'hA5;
        exp_q.push_back(8'hA5);
        step();
        chk("t1_busy_n1", 32'(busy), 32'd1);
        chk("t1_tx_n1", 32'(tx), 32'd1);
        chk("t1_level_n1", 32'(fifo_level), 32'd1);
        step();
        check_frame(8'hA5, "t1");
        chk("t1_busy_idle", 32'(busy), 32'd0);
        chk("t1_level_idle", 32'(fifo_level), 32'd0);
        step();
        chk("t1_busy_n43", 32'(busy), 32'd0);
        chk("t1_tx_n43", 32'(tx), 32'd1);

        // 2: held 00 is silent until force_send
        chk("t2_q_empty", 32'(exp_q.size()), 32'd0);
        do_reset();
        for (int i = 0; i < 200; i++) begin
            chk("t2_silent", 32'(tx), 32'd1);
            step();
        end
        force_send = 1'b1;
        exp_q.push_back(8'h00);
        step();
        force_send = 1'b0;
        chk("t2_busy_n1", 32'(busy), 32'd1);
        step();
        check_frame(8'h00, "t2");
        chk("t2_busy_end", 32'(busy), 32'd0);

        // 3: 01..06 back to back, 06 dropped
        chk("t3_q_empty", 32'(exp_q.size()), 32'd0);
        do_reset();
        step();
        for (int v = 1; v <= 6; v++) begin
            data_in = 8'(v);
            if (v <= 5) exp_q.push_back(8'(v));
            step();
        end
        chk("t3_level_full", 32'(fifo_level), 32'd4);
        chk("t3_ovf_set", 32'(overflow), 32'd1);
        repeat (215) step();
        chk("t3_ovf_sticky", 32'(overflow), 32'd1);
        chk("t3_level_drain", 32'(fifo_level), 32'd0);
        chk("t3_busy_drain", 32'(busy), 32'd0);
        chk("t3_q_drained", 32'(exp_q.size()), 32'd0);

        // 4: full FIFO, pop and push in the same IDLE cycle
        do_reset();
        step();
        for (int v = 1; v <= 5; v++) begin
            data_in = 8'(v);
            exp_q.push_back(8'(v));
            step();
        end
        chk("t4_level_full", 32'(fifo_level), 32'd4);
        repeat (37) step();
        chk("t4_level_idle", 32'(fifo_level), 32'd4);
        data_in = 8'h77;
        exp_q.push_back(8'h77);
        step();
        chk("t4_level_kept", 32'(fifo_level), 32'd4);
        chk("t4_ovf_clear", 32'(overflow), 32'd0);
        chk("t4_busy", 32'(busy), 32'd1);
        repeat (260) step();
        chk("t4_level_drain", 32'(fifo_level), 32'd0);
        chk("t4_ovf_end", 32'(overflow), 32'd0);
        chk("t4_q_drained", 32'(exp_q.size()), 32'd0);

        // 5: reset during data bit 3 of 3C, then a clean frame
        do_reset();
        step();
        data_in = 8'h3C;
        exp_q.push_back(8'h3C);
        step();
        step();
        repeat (17) step();
        rst     = 1'b1;
        data_in = 8'h00;
        exp_q.delete();
        step();
        chk("t5_tx", 32'(tx), 32'd1);
        chk("t5_level", 32'(fifo_level), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (50) step();
        chk("t5_tx_quiet", 32'(tx), 32'd1);
        data_in = 8'hC3;
        exp_q.push_back(8'hC3);
        step();
        step();
        check_frame(8'hC3, "t5");
        chk("t5_busy_end", 32'(busy), 32'd0);

        // 6: back-to-back 11, 22 with a single idle cycle between
        chk("t6_q_empty", 32'(exp_q.size()), 32'd0);
        do_reset();
        step();
        data_in = 8'h11;
        exp_q.push_back(8'h11);
        step();
        data_in = 8'h22;
        exp_q.push_back(8'h22);
        step();
        check_frame(8'h11, "t6a");
        chk("t6_gap_tx", 32'(tx), 32'd1);
        chk("t6_gap_busy", 32'(busy), 32'd1);
        step();
        check_frame(8'h22, "t6b");
        chk("t6_busy_end", 32'(busy), 32'd0);
        repeat (5) step();
        chk("t6_q_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
